// File: rtl/countdown_arbiter.sv
// countdown_arbiter: a single W-bit down-counter shared by up to N
// requesters. A round-robin arbiter picks the owner, the owner's start value
// is loaded, the counter runs to zero, and the owner gets a one-cycle done
// pulse. If the owner drops its request mid-count, the job is aborted.
// Every output comes straight from a flop.
module countdown_arbiter #(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] value,
    output logic [N-1:0]   gnt,
    output logic           busy,
    output logic [W-1:0]   count,
    output logic [N-1:0]   done,
    output logic           abort
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [N-1:0]     gnt_q;
    logic [N-1:0]     gnt_d;
    logic [W-1:0]     count_q;
    logic [W-1:0]     count_d;
    logic [N-1:0]     done_q;
    logic [N-1:0]     done_d;
    logic             abort_q;
    logic             abort_d;
    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] last_d;

    logic [IDX_W-1:0] winner;
    logic             any_req;
    logic             owner_req;
    logic             arb_ok;

    // Saturating decrement: the counter floors at zero and never wraps.
    function automatic logic [W-1:0] sat_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        if (v == '0) begin
            r = '0;
        end else begin
            r = v - 1'b1;
        end
        return r;
    endfunction

    // Round-robin pick: first set request bit searching upward from prev+1,
    // wrapping around. Returns 0 when nothing is requested; the caller
    // qualifies the result with any_req.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0] r,
                                                 input logic [IDX_W-1:0] prev);
        logic [IDX_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(prev) + k) % N;
            if (!found && r[idx]) begin
                pick  = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // One-hot decode of a requester index.
    function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N-1:0] r;
        r = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    // Start value of a requester, taken from the packed value bus.
    function automatic logic [W-1:0] start_value(input logic [N*W-1:0] vbus,
                                                 input logic [IDX_W-1:0] idx);
        return vbus[int'(idx)*W +: W];
    endfunction

    assign winner    = rr_pick(req, last_q);
    assign any_req   = |req;
    // The owner is always the most recent grantee.
    assign owner_req = req[last_q];
    // The cycle in which abort is pulsing acts as a one-cycle cool-down. The
    // next grant after an abort therefore lands two edges after the abort edge.
    assign arb_ok    = any_req && !abort_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: requester-owner handshake and count completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (arb_ok) begin
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (!owner_req) begin
                    state_d = S_IDLE;
                end else if (count_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: next values of the registered outputs and the fairness pointer.
    always_comb begin
        gnt_d   = gnt_q;
        count_d = count_q;
        done_d  = '0;
        abort_d = 1'b0;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                gnt_d = '0;
                if (arb_ok) begin
                    gnt_d   = onehot(winner);
                    count_d = start_value(value, winner);
                    last_d  = winner;
                end
            end
            S_COUNT: begin
                if (!owner_req) begin
                    abort_d = 1'b1;
                    gnt_d   = '0;
                    count_d = '0;
                end else if (count_q == '0) begin
                    done_d = onehot(last_q);
                    gnt_d  = '0;
                end else begin
                    count_d = sat_dec(count_q);
                end
            end
            S_DONE: begin
                gnt_d = '0;
            end
            default: begin
                gnt_d   = '0;
                count_d = '0;
            end
        endcase
    end

    // Output registers. Reset discards any in-flight job silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_q   <= '0;
            count_q <= '0;
            done_q  <= '0;
            abort_q <= 1'b0;
            last_q  <= IDX_W'(N - 1);
        end else begin
            gnt_q   <= gnt_d;
            count_q <= count_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            last_q  <= last_d;
        end
    end

    assign gnt   = gnt_q;
    assign count = count_q;
    assign done  = done_q;
    assign abort = abort_q;
    assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_countdown_arbiter.sv
// Directed testbench for countdown_arbiter (N=4, W=4).
module tb_countdown_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] value;
    logic [N-1:0]   gnt;
    logic           busy;
    logic [W-1:0]   count;
    logic [N-1:0]   done;
    logic           abort;

    int n_cmp = 0;
    int n_err = 0;

    countdown_arbiter #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .value (value),
        .gnt   (gnt),
        .busy  (busy),
        .count (count),
        .done  (done),
        .abort (abort)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] r;
        r = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    task automatic set_val(input int i, input int v);
        value[i*W +: W] = W'(v);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " gnt"},   32'(gnt),   32'h0);
        chk({tag, " busy"},  32'(busy),  32'h0);
        chk({tag, " count"}, 32'(count), 32'h0);
        chk({tag, " done"},  32'(done),  32'h0);
        chk({tag, " abort"}, 32'(abort), 32'h0);
    endtask

    // One complete job from the arbitration edge to the return to IDLE.
    task automatic run_job(input string tag, input int idx, input int v);
        tick;
        chk($sformatf("%s grant gnt", tag), 32'(gnt), 32'(oh(idx)));
        chk($sformatf("%s grant count", tag), 32'(count), 32'(v));
        chk($sformatf("%s grant busy", tag), 32'(busy), 32'h1);
        for (int k = 1; k <= v; k++) begin
            tick;
            chk($sformatf("%s count step %0d", tag, k), 32'(count), 32'(v - k));
            chk($sformatf("%s gnt step %0d", tag, k), 32'(gnt), 32'(oh(idx)));
            chk($sformatf("%s done low step %0d", tag, k), 32'(done), 32'h0);
        end
        tick;
        chk($sformatf("%s done pulse", tag), 32'(done), 32'(oh(idx)));
        chk($sformatf("%s gnt in DONE", tag), 32'(gnt), 32'h0);
        chk($sformatf("%s busy in DONE", tag), 32'(busy), 32'h1);
        tick;
        chk($sformatf("%s done cleared", tag), 32'(done), 32'h0);
        chk($sformatf("%s busy cleared", tag), 32'(busy), 32'h0);
    endtask

    initial begin
        // Reset with every request raised.
        rst_n = 1'b0;
        req   = 4'b1111;
        value = '0;
        set_val(0, 5);
        tick;
        chk_quiet("reset edge1");
        tick;
        chk_quiet("reset edge2");
        rst_n = 1'b1;
        tick;
        chk("post-reset gnt", 32'(gnt), 32'h1);
        chk("post-reset count", 32'(count), 32'h5);
        chk("post-reset busy", 32'(busy), 32'h1);

        // Reset mid-job while count is 5.
        rst_n = 1'b0;
        tick;
        chk_quiet("mid-job reset");
        rst_n = 1'b1;
        tick;
        chk("regrant after reset gnt", 32'(gnt), 32'h1);
        rst_n = 1'b0;
        req   = '0;
        tick;
        rst_n = 1'b1;

        // Single job on requester 2, value 3.
        set_val(2, 3);
        req = 4'b0100;
        run_job("single", 2, 3);
        req = '0;
        tick;
        chk("single idle gnt", 32'(gnt), 32'h0);
        chk("single idle busy", 32'(busy), 32'h0);

        // Fairness with all requests held.
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        set_val(0, 1);
        set_val(1, 2);
        set_val(2, 0);
        set_val(3, 3);
        req = 4'b1111;
        run_job("rr0", 0, 1);
        run_job("rr1", 1, 2);
        run_job("rr2", 2, 0);
        run_job("rr3", 3, 3);
        run_job("rr0b", 0, 1);
        req = '0;
        tick;
        chk("rr idle gnt", 32'(gnt), 32'h0);

        // Zero start value on requester 1.
        set_val(1, 0);
        req = 4'b0010;
        run_job("zero", 1, 0);
        req = '0;

        // Abort of requester 3 at count 9 with requester 0 pending.
        set_val(3, 15);
        set_val(0, 2);
        req = 4'b1001;
        tick;
        chk("abort grant gnt", 32'(gnt), 32'h8);
        chk("abort grant count", 32'(count), 32'hF);
        for (int k = 1; k <= 6; k++) begin
            tick;
            chk($sformatf("abort count step %0d", k), 32'(count), 32'(15 - k));
        end
        req = 4'b0001;
        tick;
        chk("abort pulse", 32'(abort), 32'h1);
        chk("abort gnt", 32'(gnt), 32'h0);
        chk("abort count", 32'(count), 32'h0);
        chk("abort done", 32'(done), 32'h0);
        chk("abort busy", 32'(busy), 32'h0);
        tick;
        chk("abort pulse end", 32'(abort), 32'h0);
        chk("abort cooldown gnt", 32'(gnt), 32'h0);
        chk("abort no done", 32'(done), 32'h0);
        tick;
        chk("pending grant gnt", 32'(gnt), 32'h1);
        chk("pending grant count", 32'(count), 32'h2);
        chk("pending grant busy", 32'(busy), 32'h1);
        req = '0;
        tick;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/countdown_arbiter.md
# countdown_arbiter

Shared countdown-timer resource with a round-robin arbiter. Up to N requesters each present a start value. The block grants the single internal W-bit down-counter to one requester at a time, loads that requester's value, counts to zero, and returns a one-cycle completion pulse to the owner. It sits between the requesting control blocks and the decrementer datapath, replacing per-requester counters with one time-shared counter.

## Interface
- N, default 4: number of requesters (2..8).
- W, default 4: counter width in bits.

- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low; sampled on rising edge of clk.
- req  input  N  per-requester request level; held high until done or abort.
- value  input  N*W  start values; requester i at bits [i*W +: W]; sampled only on the grant edge.
- gnt  output  N  one-hot grant; high from grant edge until the job leaves COUNT.
- busy  output  1  high whenever state is not IDLE.
- count  output  W  current counter value.
- done  output  N  one-cycle pulse on the owner's bit when its count completes.
- abort  output  1  one-cycle pulse when the owner drops req mid-count.

## Operation
- States: IDLE, COUNT, DONE.
- IDLE:
  - If any req bit is high, the winner is the first set bit searching from (last+1) mod N, upward with wrap.
  - Grant edge: gnt <= onehot(winner), count <= value[winner], last <= winner, state <= COUNT.
  - If no req bit is high, stay in IDLE.
- COUNT, evaluated in priority order:
  - If req[owner] is low: abort <= 1, gnt <= 0, count <= 0, state <= IDLE. No done.
  - Else if count == 0: done[owner] <= 1, gnt <= 0, state <= DONE.
  - Else: count <= count - 1.
  - Requests from other requesters are ignored; they stay pending.
- DONE:
  - Lasts exactly one cycle. done is high during it.
  - Next edge: done <= 0, state <= IDLE. req is not sampled here.
  - This gives the owner one full cycle to drop req.
- Arithmetic is unsigned, W bits. The counter never decrements below 0; there is no wrap-around.
- value == 0: the grant edge loads 0; the next edge takes the count == 0 path and done fires.
- Round-robin:
  - last resets to N-1, so requester 0 has the highest priority first.
  - last is updated only on a grant.
  - Aborted and completed jobs both advance fairness.
- If a requester keeps req high after DONE, it is treated as a new job and competes normally in IDLE.
- Reset (any cycle, including mid-COUNT or in DONE): state <= IDLE, gnt = 0, busy = 0, count = 0, done = 0, abort = 0, last = N-1. The in-flight job is discarded with no done and no abort.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- With grant at edge G and start value V (no abort):
  - count = V after G, then V-1 … 0 on successive edges.
  - done is high in the cycle after edge G+V+1.
  - gnt is high for V+1 cycles.
- Job turnaround is V+4 edges from IDLE to the next possible grant: grant, V decrements, a DONE edge, an IDLE edge, then arbitration. The next grant lands at edge G+V+3.
- Abort is detected on the first edge where req[owner] is sampled low in COUNT. abort pulses for one cycle. The next grant is no earlier than 2 edges later.
- busy = 1 from the grant edge through the DONE cycle inclusive.

## Test plan
- Reset: rst_n low for 2 edges with req = 4'b1111 → gnt = 0, busy = 0, count = 0, done = 0, abort = 0 throughout; the first grant after release goes to requester 0.
- Single job: req = 4'b0100, value[2] = 3 → gnt = 4'b0100 at edge 1; count reads 3, 2, 1, 0; done = 4'b0100 for exactly 1 cycle; gnt = 0 during DONE.
- Fairness: req = 4'b1111 with values 1, 2, 0, 3 held after each done → grant order 0, 1, 2, 3, 0; each done pulse lands on the matching bit with the expected cycle count.
- Zero value: req[1] with value 0 → done[1] one cycle after grant; gnt is high for exactly 1 cycle.
- Abort: req[3] with value 15; drop req[3] when count = 9 → abort pulses once, count = 0, gnt = 0, no done; a pending req[0] is granted 2 edges later.
- Reset mid-job: pull rst_n low while count = 5 → next edge count = 0, gnt = 0, busy = 0, with no done and no abort pulse.
